// File: rtl/fc_in_serializer_pkg.sv
// Shared definitions for the LSTM network datapath blocks.
//
// Holds the serializer state encoding and the element-counter width helper so
// that every block sizing a counter over UNITS_NUM elements agrees on it.
package fc_in_serializer_pkg;

    // Serializer control state: idle (nothing on x_o) or streaming a vector.
    typedef enum logic {
        FC_IDLE   = 1'b0,
        FC_STREAM = 1'b1
    } fc_state_e;

    // Counter width able to index n elements; never narrower than one bit.
    function automatic int fc_cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fc_in_serializer.sv
// Parallel-to-serial converter between the LSTM hidden-state output and the
// fully-connected input stage.
//
// A full hidden vector (UNITS_NUM elements of D_WL bits) is captured in one
// handshake and replayed one element per cycle, element 0 first. A shadow
// buffer lets the next vector be accepted while the current one streams, so
// consecutive vectors come out with no idle cycle in between. There is no
// downstream backpressure: once started, a vector always takes exactly
// UNITS_NUM cycles.
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   h_valid  : h_in carries a vector
//   h_in     : packed vector, element k at h_in[k*D_WL +: D_WL]
//   h_ready  : vector accepted on this edge if h_valid is also high
//   o_valid  : x_o carries an element
//   x_o      : serial element stream (0 when idle)
//   o_last   : x_o is the final element of its vector
//   busy     : a vector is streaming or waiting in the shadow buffer
module fc_in_serializer
    import fc_in_serializer_pkg::*;
#(
    parameter int UNITS_NUM = 30,
    parameter int D_WL      = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      h_valid,
    input  logic [UNITS_NUM*D_WL-1:0] h_in,
    output logic                      h_ready,
    output logic                      o_valid,
    output logic [D_WL-1:0]           x_o,
    output logic                      o_last,
    output logic                      busy
);

    localparam int CNT_W = fc_cnt_width(UNITS_NUM);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(UNITS_NUM - 1);

    typedef logic [UNITS_NUM-1:0][D_WL-1:0] vec_t;

    fc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    vec_t             active_q, active_d;
    vec_t             shadow_q, shadow_d;
    logic             shadow_full_q, shadow_full_d;
    logic             o_valid_q, o_valid_d;
    logic             o_last_q, o_last_d;
    logic [D_WL-1:0]  x_o_q, x_o_d;

    vec_t h_vec;
    logic accept;
    logic at_last;

    assign h_vec   = h_in;
    // Ready depends only on a flop, so there is no path from h_valid.
    assign h_ready = ~shadow_full_q;
    assign accept  = h_valid & ~shadow_full_q;
    assign at_last = (state_q == FC_STREAM) && (cnt_q == LAST_IDX);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        active_d      = active_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;

        case (state_q)
            FC_IDLE: begin
                if (accept) begin
                    active_d = h_vec;
                    state_d  = FC_STREAM;
                    cnt_d    = '0;
                end
            end
            FC_STREAM: begin
                if (at_last) begin
                    cnt_d = '0;
                    if (shadow_full_q) begin
                        // Pending vector takes over with no bubble; accept is
                        // impossible here because h_ready is low.
                        active_d      = shadow_q;
                        shadow_full_d = 1'b0;
                    end else if (accept) begin
                        // Arrived exactly on the last element: go straight
                        // to active rather than parking in the shadow.
                        active_d = h_vec;
                    end else begin
                        state_d = FC_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (accept) begin
                        shadow_d      = h_vec;
                        shadow_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = FC_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered from next-state values so x_o lines up with
        // the counter one cycle after acceptance.
        o_valid_d = (state_d == FC_STREAM);
        o_last_d  = (state_d == FC_STREAM) && (cnt_d == LAST_IDX);
        x_o_d     = (state_d == FC_STREAM) ? active_d[cnt_d] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FC_IDLE;
            cnt_q         <= '0;
            shadow_full_q <= 1'b0;
            o_valid_q     <= 1'b0;
            o_last_q      <= 1'b0;
            x_o_q         <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_full_q <= shadow_full_d;
            o_valid_q     <= o_valid_d;
            o_last_q      <= o_last_d;
            x_o_q         <= x_o_d;
        end
    end

    // Buffer contents are only observed through the state above, so they
    // carry no reset.
    always_ff @(posedge clk) begin
        active_q <= active_d;
        shadow_q <= shadow_d;
    end

    assign o_valid = o_valid_q;
    assign o_last  = o_last_q;
    assign x_o     = x_o_q;
    assign busy    = (state_q == FC_STREAM) | shadow_full_q;

endmodule

// File: tb/tb_fc_in_serializer.sv
// Self-checking bench for fc_in_serializer.
//
// The reference model treats the block as a FIFO of elements still to be
// emitted: an accepted vector appends UNITS_NUM elements, each cycle emits the
// head. Remaining-count alone gives every output: the head is x_o, a count
// that is 1 mod UNITS_NUM marks the last element, and a new vector fits only
// when at most one vector's worth remains.
module tb_fc_in_serializer;

    localparam int N  = 30;
    localparam int W  = 24;
    localparam int VW = N * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          h_valid;
    logic [VW-1:0] h_in;
    logic          h_ready;
    logic          o_valid;
    logic [W-1:0]  x_o;
    logic          o_last;
    logic          busy;

    fc_in_serializer #(.UNITS_NUM(N), .D_WL(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .h_valid (h_valid),
        .h_in    (h_in),
        .h_ready (h_ready),
        .o_valid (o_valid),
        .x_o     (x_o),
        .o_last  (o_last),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Vector patterns: 0 k+1, 1 100+k, 2 signed extremes, 3 random.
    function automatic logic [VW-1:0] mkvec(input int mode);
        logic [VW-1:0] v;
        logic [W-1:0]  e;
        v = '0;
        for (int k = 0; k < N; k++) begin
            case (mode)
                0:       e = W'(k + 1);
                1:       e = W'(100 + k);
                2:       e = (k % 2 == 0) ? 24'h800000 : 24'h7FFFFF;
                default: e = W'($urandom);
            endcase
            v[k*W +: W] = e;
        end
        return v;
    endfunction

    // One clock: check the current outputs against the model, then drive the
    // inputs for the coming edge and advance the model across it.
    task automatic cyc(input logic v, input logic r, input logic [VW-1:0] vec);
        int  s;
        logic acc;
        @(negedge clk);
        s = exp_q.size();
        chk("o_valid", 32'(o_valid), 32'(s > 0));
        chk("x_o",     32'(x_o),     (s > 0) ? 32'(exp_q[0]) : 32'd0);
        chk("o_last",  32'(o_last),  32'((s > 0) && (s % N == 1)));
        chk("h_ready", 32'(h_ready), 32'(s <= N));
        chk("busy",    32'(busy),    32'(s > 0));
        h_valid = v;
        h_in    = vec;
        rst     = r;
        if (r) begin
            exp_q.delete();
        end else begin
            acc = v && (s <= N);
            if (s > 0) void'(exp_q.pop_front());
            if (acc)
                for (int k = 0; k < N; k++) exp_q.push_back(vec[k*W +: W]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, mkvec(3));
    endtask

    initial begin
        rst     = 1'b1;
        h_valid = 1'b0;
        h_in    = '0;
        @(posedge clk);
        // Reset state with random junk offered while rst is held.
        cyc(1'b1, 1'b1, mkvec(3));
        cyc(1'b0, 1'b0, mkvec(3));
        idle(2);

        // Single vector, element k = k+1.
        cyc(1'b1, 1'b0, mkvec(0));
        idle(34);

        // Back-to-back: second vector accepted five cycles later.
        cyc(1'b1, 1'b0, mkvec(0));
        idle(4);
        cyc(1'b1, 1'b0, mkvec(1));
        // Offer a third while the shadow is full; it must be refused.
        cyc(1'b1, 1'b0, mkvec(3));
        idle(64);

        // Accept exactly in the o_last cycle with the shadow empty.
        cyc(1'b1, 1'b0, mkvec(0));
        idle(29);
        cyc(1'b1, 1'b0, mkvec(1));
        idle(34);

        // Reset mid-stream around element 12.
        cyc(1'b1, 1'b0, mkvec(0));
        idle(11);
        cyc(1'b0, 1'b1, mkvec(3));
        idle(5);

        // Reset with the shadow full discards both buffers.
        cyc(1'b1, 1'b0, mkvec(1));
        idle(3);
        cyc(1'b1, 1'b0, mkvec(0));
        idle(5);
        cyc(1'b0, 1'b1, mkvec(3));
        idle(40);

        // Signed extremes, two vectors back to back.
        cyc(1'b1, 1'b0, mkvec(2));
        idle(10);
        cyc(1'b1, 1'b0, mkvec(2));
        idle(55);

        // Random traffic with occasional reset.
        for (int i = 0; i < 1500; i++)
            cyc(($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
                ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                mkvec(3));
        idle(70);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fc_in_serializer.md
FC_IN_SERIALIZER -- requirements
Module: fc_in_serializer

Interface
REQ-001 The block SHALL have parameter UNITS_NUM, default 30: number of hidden elements per vector, equal to the downstream fully-connected INPUT_SIZE.
REQ-002 The block SHALL have parameter D_WL, default 24: element width, two's-complement fixed point, passed through unmodified.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port h_valid, input, 1: a parallel hidden-state vector is present on h_in.
REQ-007 Port h_in, input, UNITS_NUM*D_WL: packed vector; element k is h_in[k*D_WL +: D_WL].
REQ-008 Port h_ready, output, 1: block accepts h_in this cycle.
REQ-009 Port o_valid, output, 1: x_o carries a valid element; drives the fully-connected stage in_valid.
REQ-010 Port x_o, output, D_WL: serial element stream.
REQ-011 Port o_last, output, 1: x_o is element UNITS_NUM-1 of the current vector.
REQ-012 Port busy, output, 1: stream in progress or vector pending.

Function
REQ-013 A vector SHALL be accepted only on the rising edge where h_valid and h_ready are both 1.
REQ-014 The block SHALL hold an active buffer, a shadow buffer, a shadow_full flag, a state (IDLE, STREAM) and an element counter of clog2(UNITS_NUM) bits.
REQ-015 h_ready SHALL equal not shadow_full, with no combinational path from h_valid.
REQ-016 An accepted vector SHALL load the active buffer directly when state is IDLE, or when state is STREAM with o_last=1 and shadow_full=0; otherwise it SHALL load the shadow buffer and set shadow_full.
REQ-017 IDLE to STREAM SHALL occur on acceptance, with counter=0; the first element SHALL appear on x_o the cycle after acceptance (latency 1).
REQ-018 In STREAM, x_o SHALL equal active element [counter], with o_valid=1 every cycle, and the counter SHALL increment by 1 per cycle.
REQ-019 Elements SHALL be emitted in order 0 to UNITS_NUM-1, contiguously, with exactly UNITS_NUM o_valid cycles per vector.
REQ-020 When o_last=1 and shadow_full=1, the shadow SHALL move to active, shadow_full SHALL clear, the counter SHALL wrap to 0 and the state SHALL stay STREAM (no bubble).
REQ-021 When o_last=1, shadow_full=1 and a vector is accepted in the same cycle: this cannot occur, because h_ready=0.
REQ-022 When o_last=1, shadow_full=0 and a vector is accepted: the new vector SHALL go to active, the counter SHALL wrap to 0 and the state SHALL stay STREAM.
REQ-023 When o_last=1, shadow_full=0 and no vector is accepted: the state SHALL go to IDLE.
REQ-024 In IDLE, o_valid SHALL be 0, o_last SHALL be 0 and x_o SHALL be 0.
REQ-025 o_last SHALL be 1 only when o_valid=1 and counter=UNITS_NUM-1.
REQ-026 busy SHALL equal (state==STREAM) or shadow_full.
REQ-027 The block SHALL have no backpressure from downstream; the stream is never stalled.

Reset
REQ-028 rst=1 SHALL force IDLE, counter=0, shadow_full=0, o_valid=0, o_last=0, x_o=0, h_ready=1 and busy=0 on the next edge.
REQ-029 Reset asserted mid-stream SHALL discard both buffers; no further o_valid until a new acceptance after rst deasserts.
REQ-030 Buffer data registers need not be reset.

Structure
REQ-031 State encoding (IDLE, STREAM) and the counter-width function SHALL live in the shared LSTM network package.
REQ-032 The block SHALL be a single module with no sub-modules; element selection SHALL be a registered mux.

Verification
REQ-033 Single vector: with element k = k+1, accept at cycle 0 -> o_valid in cycles 1 to 30, x_o = 1..30, o_last only in cycle 30, IDLE in cycle 31.
REQ-034 Back-to-back: second vector (element k = 100+k) accepted at cycle 5 -> h_ready=0 in cycles 6 to 30, x_o=100 in cycle 31 with no gap, 60 contiguous o_valid cycles.
REQ-035 Accept on last: second vector offered exactly in the o_last cycle with shadow empty -> element 0 of the new vector appears in the next cycle, with no gap.
REQ-036 Reset mid-stream: rst=1 for 1 cycle at element 12 -> o_valid=0 the next cycle, h_ready=1, busy=0, and no stale elements after reset.
REQ-037 Signed extremes: elements alternating 24'h800000 and 24'h7FFFFF -> x_o bit-exact.
REQ-038 End-to-end with fully-connected stage: streamed vector -> class outputs equal the golden model within 0 LSB.
